// File: rtl/bram_fifo_ctrl_if.sv
// Bus interface for bram_fifo_ctrl: FIFO user handshake plus the RAM port.
// The optional error flags (ovf/unf) exist only when
// BRAM_FIFO_CTRL_ERR_FLAGS_EN is defined.
interface bram_fifo_ctrl_if;
    logic        push;
    logic [31:0] push_data;
    logic        pop;
    logic [31:0] pop_data;
    logic        pop_valid;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic [9:0]  count;
    logic        ram_wen;
    logic [8:0]  ram_waddr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_wenb;
    logic        ram_ren;
    logic [8:0]  ram_raddr;
    logic [31:0] ram_rdata;
`ifdef BRAM_FIFO_CTRL_ERR_FLAGS_EN
    logic        ovf;
    logic        unf;
`endif

    // Controller side
    modport slave (
        input  push, push_data, pop, ram_rdata,
        output pop_data, pop_valid, full, empty, almost_full, count,
               ram_wen, ram_waddr, ram_wdata, ram_wenb, ram_ren, ram_raddr
`ifdef BRAM_FIFO_CTRL_ERR_FLAGS_EN
        , output ovf, unf
`endif
    );

    // User / RAM side
    modport master (
        output push, push_data, pop, ram_rdata,
        input  pop_data, pop_valid, full, empty, almost_full, count,
               ram_wen, ram_waddr, ram_wdata, ram_wenb, ram_ren, ram_raddr
`ifdef BRAM_FIFO_CTRL_ERR_FLAGS_EN
        , input ovf, unf
`endif
    );
endinterface

// File: rtl/bram_fifo_ctrl.sv
// Single-clock FIFO controller driving an external 512x32 dual-port RAM
// with registered read data (1-cycle read latency).
// Optional sticky overflow/underflow flags: define BRAM_FIFO_CTRL_ERR_FLAGS_EN.
module bram_fifo_ctrl #(
    parameter int AF_LEVEL = 480
) (
    input  logic             C,
    input  logic             R,
    bram_fifo_ctrl_if.slave  bus
);

    // 10-bit pointers: [8:0] is the RAM address, [9] is the wrap bit
    logic [9:0]  r_wr_ptr;
    logic [9:0]  r_rd_ptr;
    logic [9:0]  r_count;
    logic        r_full;
    logic        r_empty;
    logic        r_almost_full;
    logic        r_pop_valid;

    logic        w_push_acc;
    logic        w_pop_acc;
    logic [9:0]  w_wr_nxt;
    logic [9:0]  w_rd_nxt;
    logic [9:0]  w_count_nxt;

    // Acceptance is gated by R so the RAM strobes stay inactive during reset
    assign w_push_acc  = R & bus.push & ~r_full;
    assign w_pop_acc   = R & bus.pop  & ~r_empty;
    assign w_wr_nxt    = r_wr_ptr + {9'd0, w_push_acc};
    assign w_rd_nxt    = r_rd_ptr + {9'd0, w_pop_acc};
    assign w_count_nxt = w_wr_nxt - w_rd_nxt;

    // Pointer, occupancy and status flag registers, computed from next-state values
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            r_wr_ptr      <= 10'd0;
            r_rd_ptr      <= 10'd0;
            r_count       <= 10'd0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_almost_full <= 1'b0;
            r_pop_valid   <= 1'b0;
        end else begin
            r_wr_ptr      <= w_wr_nxt;
            r_rd_ptr      <= w_rd_nxt;
            r_count       <= w_count_nxt;
            r_full        <= (w_count_nxt == 10'd512);
            r_empty       <= (w_count_nxt == 10'd0);
            r_almost_full <= (w_count_nxt >= 10'(AF_LEVEL));
            r_pop_valid   <= w_pop_acc;
        end
    end

    // RAM strobes/addresses must act in the same cycle as the request
    always_comb begin
        bus.ram_wen   = 1'b1;
        bus.ram_waddr = r_wr_ptr[8:0];
        bus.ram_wdata = bus.push_data;
        bus.ram_ren   = 1'b1;
        bus.ram_raddr = r_rd_ptr[8:0];
        if (w_push_acc) begin
            bus.ram_wen = 1'b0;
        end else begin
            bus.ram_wen = 1'b1;
        end
        if (w_pop_acc) begin
            bus.ram_ren = 1'b0;
        end else begin
            bus.ram_ren = 1'b1;
        end
    end

    assign bus.ram_wenb    = 32'hFFFF_FFFF;
    assign bus.pop_data    = bus.ram_rdata;
    assign bus.pop_valid   = r_pop_valid;
    assign bus.full        = r_full;
    assign bus.empty       = r_empty;
    assign bus.almost_full = r_almost_full;
    assign bus.count       = r_count;

`ifdef BRAM_FIFO_CTRL_ERR_FLAGS_EN
    logic r_ovf;
    logic r_unf;

    // Sticky error flags: only reset clears them
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= r_ovf | (bus.push & r_full);
            r_unf <= r_unf | (bus.pop & r_empty);
        end
    end

    assign bus.ovf = r_ovf;
    assign bus.unf = r_unf;
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed self-checking bench for bram_fifo_ctrl with a behavioural
// 512x32 RAM (registered read) attached to the RAM port.
module tb_bram_fifo_ctrl;

    logic C;
    logic R;
    int   checks;
    int   errors;

    bram_fifo_ctrl_if bus();

    bram_fifo_ctrl #(.AF_LEVEL(480)) dut (
        .C   (C),
        .R   (R),
        .bus (bus)
    );

    logic [31:0] mem [512];

    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    // Behavioural RAM: write on ram_wen=0, registered read on ram_ren=0
    always @(posedge C) begin
        if (!bus.ram_wen) mem[bus.ram_waddr] <= bus.ram_wdata;
        if (!bus.ram_ren) bus.ram_rdata <= mem[bus.ram_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic drive(input logic p, input logic [31:0] d, input logic q);
        bus.push      = p;
        bus.push_data = d;
        bus.pop       = q;
        #1;
    endtask

    initial begin
        logic [8:0] exp_wa;
        int         qi;
        checks = 0;
        errors = 0;
        R = 1'b1;
        bus.push = 1'b0;
        bus.push_data = 32'd0;
        bus.pop = 1'b0;

        // Reset with requests active: strobes must stay high
        #2 R = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 1'b1);
        chk("rst_wen", {31'd0, bus.ram_wen}, 32'd1);
        chk("rst_ren", {31'd0, bus.ram_ren}, 32'd1);
        tick();
        tick();
        chk("rst_empty", {31'd0, bus.empty}, 32'd1);
        chk("rst_full", {31'd0, bus.full}, 32'd0);
        chk("rst_af", {31'd0, bus.almost_full}, 32'd0);
        chk("rst_count", {22'd0, bus.count}, 32'd0);
        chk("rst_pv", {31'd0, bus.pop_valid}, 32'd0);
`ifdef BRAM_FIFO_CTRL_ERR_FLAGS_EN
        chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
        chk("rst_unf", {31'd0, bus.unf}, 32'd0);
`endif
        drive(1'b0, 32'd0, 1'b0);
        R = 1'b1;
        tick();

        // Push 1..3 then pop 3 back-to-back
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(i + 1), 1'b0);
            chk("b_wen", {31'd0, bus.ram_wen}, 32'd0);
            chk("b_waddr", {23'd0, bus.ram_waddr}, 32'(i));
            chk("b_wdata", bus.ram_wdata, 32'(i + 1));
            tick();
        end
        chk("b_count3", {22'd0, bus.count}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'd0, 1'b1);
            chk("b_ren", {31'd0, bus.ram_ren}, 32'd0);
            chk("b_raddr", {23'd0, bus.ram_raddr}, 32'(i));
            tick();
            chk("b_pv", {31'd0, bus.pop_valid}, 32'd1);
            chk("b_pdata", bus.pop_data, 32'(i + 1));
        end
        drive(1'b0, 32'd0, 1'b0);
        tick();
        chk("b_pv_end", {31'd0, bus.pop_valid}, 32'd0);
        chk("b_empty", {31'd0, bus.empty}, 32'd1);

        // Fill to 512; write pointer starts at address 3
        for (int i = 0; i < 512; i++) begin
            drive(1'b1, 32'hA000_0000 + 32'(i), 1'b0);
            if (i == 0) chk("f_waddr0", {23'd0, bus.ram_waddr}, 32'd3);
            if (i == 509) chk("f_waddr_wrap", {23'd0, bus.ram_waddr}, 32'd0);
            tick();
            if (i == 478) chk("f_af479", {31'd0, bus.almost_full}, 32'd0);
            if (i == 479) begin
                chk("f_af480", {31'd0, bus.almost_full}, 32'd1);
                chk("f_cnt480", {22'd0, bus.count}, 32'd480);
            end
            if (i == 510) chk("f_full511", {31'd0, bus.full}, 32'd0);
        end
        chk("f_full", {31'd0, bus.full}, 32'd1);
        chk("f_count", {22'd0, bus.count}, 32'd512);

        // 513th push is ignored
        drive(1'b1, 32'hBAD0_0000, 1'b0);
        chk("o_wen", {31'd0, bus.ram_wen}, 32'd1);
        tick();
        chk("o_count", {22'd0, bus.count}, 32'd512);
`ifdef BRAM_FIFO_CTRL_ERR_FLAGS_EN
        chk("o_ovf", {31'd0, bus.ovf}, 32'd1);
`endif

        // Push+pop while full: push ignored, pop taken
        drive(1'b1, 32'hBAD0_0001, 1'b1);
        chk("pp_wen", {31'd0, bus.ram_wen}, 32'd1);
        chk("pp_ren", {31'd0, bus.ram_ren}, 32'd0);
        chk("pp_raddr", {23'd0, bus.ram_raddr}, 32'd3);
        tick();
        chk("pp_count", {22'd0, bus.count}, 32'd511);
        chk("pp_full", {31'd0, bus.full}, 32'd0);
        chk("pp_pv", {31'd0, bus.pop_valid}, 32'd1);
        chk("pp_pdata", bus.pop_data, 32'hA000_0000);

        // Drain the remaining 511 words in order
        for (int i = 1; i < 512; i++) begin
            drive(1'b0, 32'd0, 1'b1);
            tick();
            chk("d_pdata", bus.pop_data, 32'hA000_0000 + 32'(i));
        end
        drive(1'b0, 32'd0, 1'b0);
        tick();
        chk("d_empty", {31'd0, bus.empty}, 32'd1);
        chk("d_pv", {31'd0, bus.pop_valid}, 32'd0);

        // Stream 700 words at occupancy 5; pointers wrap past 511
        exp_wa = 9'd3;
        qi = 0;
        for (int n = 0; n < 705; n++) begin
            drive(n < 700, 32'h5000_0000 + 32'(n), n >= 5);
            if (n < 700) begin
                chk("s_waddr", {23'd0, bus.ram_waddr}, {23'd0, exp_wa});
                exp_wa = exp_wa + 9'd1;
            end
            tick();
            chk("s_pv", {31'd0, bus.pop_valid}, (n >= 5) ? 32'd1 : 32'd0);
            if (n >= 5) begin
                chk("s_pdata", bus.pop_data, 32'h5000_0000 + 32'(qi));
                qi++;
            end
            if (n == 300) chk("s_count", {22'd0, bus.count}, 32'd5);
        end
        drive(1'b0, 32'd0, 1'b0);
        tick();
        chk("s_empty", {31'd0, bus.empty}, 32'd1);
        chk("s_count0", {22'd0, bus.count}, 32'd0);

        // Pop while empty with push in same cycle
        drive(1'b1, 32'h1111_0000, 1'b1);
        chk("u_ren", {31'd0, bus.ram_ren}, 32'd1);
        chk("u_wen", {31'd0, bus.ram_wen}, 32'd0);
        tick();
        chk("u_pv", {31'd0, bus.pop_valid}, 32'd0);
        chk("u_count", {22'd0, bus.count}, 32'd1);
`ifdef BRAM_FIFO_CTRL_ERR_FLAGS_EN
        chk("u_unf", {31'd0, bus.unf}, 32'd1);
`endif

        // Bring count to 10, pop once, reset with pop_valid pending
        for (int i = 1; i < 10; i++) begin
            drive(1'b1, 32'h1111_0000 + 32'(i), 1'b0);
            tick();
        end
        chk("r_count10", {22'd0, bus.count}, 32'd10);
        drive(1'b0, 32'd0, 1'b1);
        tick();
        chk("r_pv_pre", {31'd0, bus.pop_valid}, 32'd1);
        R = 1'b0;
        #1;
        chk("r_pv", {31'd0, bus.pop_valid}, 32'd0);
        chk("r_count", {22'd0, bus.count}, 32'd0);
        chk("r_empty", {31'd0, bus.empty}, 32'd1);
        chk("r_ren", {31'd0, bus.ram_ren}, 32'd1);
        drive(1'b0, 32'd0, 1'b0);
        R = 1'b1;
        tick();
        drive(1'b1, 32'hCAFE_0001, 1'b0);
        tick();
        drive(1'b1, 32'hCAFE_0002, 1'b0);
        tick();
        drive(1'b0, 32'd0, 1'b1);
        tick();
        chk("r_pv_post", {31'd0, bus.pop_valid}, 32'd1);
        chk("r_pdata", bus.pop_data, 32'hCAFE_0001);
        chk("r_count1", {22'd0, bus.count}, 32'd1);
        drive(1'b0, 32'd0, 1'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
